// File: rtl/display_scanner_if.sv
// Bus bundle between a display host and display_scanner.
// NUM_DIGITS must match the scanner's NUM_DIGITS parameter.
interface display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic                    lz_en;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load_ack;
  logic                    frame_done;

  modport master (
    output en, load, data_in, lz_en,
    input  nibble, digit_en, load_ack, frame_done
  );

  modport slave (
    input  en, load, data_in, lz_en,
    output nibble, digit_en, load_ack, frame_done
  );
endinterface

// File: rtl/display_scanner.sv
// Multiplexed seven-segment scan controller: double-buffered display word,
// blank gap before every digit slot, optional leading-zero suppression.
module display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  display_scanner_if.slave bus
);
  localparam int W    = 4 * NUM_DIGITS;
  localparam int MAXC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [1:0]            state_reg, state_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [W-1:0]          display_reg, display_next;
  logic [W-1:0]          shadow_reg;
  logic                  pending_reg;
  logic [3:0]            nibble_reg;
  logic [NUM_DIGITS-1:0] digit_en_reg;
  logic                  load_ack_reg;
  logic                  frame_done_reg;

  logic                  commit;
  logic                  frame_end;
  logic                  upper_zero;
  logic [3:0]            next_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_zero;
  logic [NUM_DIGITS-1:0] suppress;
  logic [NUM_DIGITS-1:0] onehot;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    frame_end  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.en) begin
          commit     = 1'b1;
          idx_next   = '0;
          cnt_next   = '0;
          state_next = BLANK;
        end
      end
      BLANK: begin
        if (cnt_reg == BLANK_LAST) begin
          cnt_next   = '0;
          state_next = SHOW;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      SHOW: begin
        if (cnt_reg == SHOW_LAST) begin
          cnt_next = '0;
          if (idx_reg == IDX_LAST) begin
            frame_end  = 1'b1;
            commit     = 1'b1;
            idx_next   = '0;
            state_next = bus.en ? BLANK : IDLE;
          end else begin
            idx_next   = idx_reg + IW'(1);
            state_next = BLANK;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so the newly committed
  // word already drives nibble during the first blank slot of its frame.
  assign display_next = (commit && pending_reg) ? shadow_reg : display_reg;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign next_digit[gi] = display_next[4*gi +: 4];
      assign digit_zero[gi] = (display_next[4*gi +: 4] == 4'd0);
    end
  endgenerate

  always_comb begin
    upper_zero = 1'b1;
    suppress   = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero & digit_zero[i];
      suppress[i] = bus.lz_en & upper_zero;
    end
  end

  assign onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      display_reg    <= '0;
      shadow_reg     <= '0;
      pending_reg    <= 1'b0;
      nibble_reg     <= 4'd0;
      digit_en_reg   <= '0;
      load_ack_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      display_reg    <= display_next;
      if (bus.load) begin
        shadow_reg <= bus.data_in;
      end
      // A load on the commit edge re-arms pending for the following frame.
      pending_reg    <= bus.load | (pending_reg & ~commit);
      load_ack_reg   <= commit & pending_reg;
      frame_done_reg <= frame_end;
      nibble_reg     <= (state_next == IDLE) ? 4'd0 : next_digit[idx_next];
      digit_en_reg   <= (state_next == SHOW && !suppress[idx_next]) ? onehot : '0;
    end
  end

  assign bus.nibble     = nibble_reg;
  assign bus.digit_en   = digit_en_reg;
  assign bus.load_ack   = load_ack_reg;
  assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with defaults (4 digits, dwell 4, blank 1).
module tb_display_scanner;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic idle_bad;

  always #5 clk = ~clk;

  display_scanner_if #(.NUM_DIGITS(4)) bus ();

  display_scanner #(
    .NUM_DIGITS(4),
    .PRESCALE(4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Walks one 20-cycle frame starting at the observation point right after
  // the edge that entered digit 0's blank slot; ends just after the boundary edge.
  task automatic frame(input logic [15:0] val, input logic [3:0] mask,
                       input int la1, input logic [15:0] d1,
                       input int la2, input logic [15:0] d2,
                       input int endrop);
    int c;
    logic [3:0] exp_en;
    c = 0;
    for (int d = 0; d < 4; d++) begin
      for (int s = 0; s < 5; s++) begin
        exp_en = (s == 0 || !mask[d]) ? 4'b0000 : (4'b0001 << d);
        check($sformatf("digit_en c%0d", c), bus.digit_en, exp_en);
        check($sformatf("nibble c%0d", c), bus.nibble, val[4*d +: 4]);
        if (c > 0) begin
          check($sformatf("load_ack c%0d", c), bus.load_ack, 1'b0);
          check($sformatf("frame_done c%0d", c), bus.frame_done, 1'b0);
        end
        if (c == la1) begin
          bus.load = 1'b1;
          bus.data_in = d1;
        end else if (c == la2) begin
          bus.load = 1'b1;
          bus.data_in = d2;
        end
        if (c == endrop) bus.en = 1'b0;
        tick();
        bus.load = 1'b0;
        c++;
      end
    end
  endtask

  task automatic boundary(input string tag, input logic exp_ack);
    check({tag, " frame_done"}, bus.frame_done, 1'b1);
    check({tag, " load_ack"}, bus.load_ack, exp_ack);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.load = 1'b0;
    bus.data_in = 16'h0;
    bus.lz_en = 1'b0;

    // Reset held two cycles with en high
    tick();
    tick();
    check("rst nibble", bus.nibble, 4'h0);
    check("rst digit_en", bus.digit_en, 4'h0);
    check("rst load_ack", bus.load_ack, 1'b0);
    check("rst frame_done", bus.frame_done, 1'b0);
    rst_n = 1'b1;
    bus.en = 1'b0;
    idle_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.digit_en !== 4'h0) idle_bad = 1'b1;
    end
    check("idle 100 digit_en", idle_bad, 1'b0);

    // Basic scan of 1234
    bus.load = 1'b1;
    bus.data_in = 16'h1234;
    tick();
    bus.load = 1'b0;
    check("idle load no ack", bus.load_ack, 1'b0);
    bus.en = 1'b1;
    tick();
    check("start load_ack", bus.load_ack, 1'b1);
    check("start frame_done", bus.frame_done, 1'b0);
    frame(16'h1234, 4'hF, -1, 16'h0, -1, 16'h0, -1);
    boundary("f1", 1'b0);

    // Mid-frame loads: remainder still shows 1234, single ack at boundary
    frame(16'h1234, 4'hF, 7, 16'hABCD, 9, 16'h5678, -1);
    boundary("f2", 1'b1);

    // 4321 pending, 9999 loaded on the commit edge
    frame(16'h5678, 4'hF, 3, 16'h4321, 19, 16'h9999, -1);
    boundary("f3", 1'b1);
    frame(16'h4321, 4'hF, -1, 16'h0, -1, 16'h0, -1);
    boundary("f4", 1'b1);

    // Leading-zero suppression
    bus.lz_en = 1'b1;
    frame(16'h9999, 4'hF, 2, 16'h0070, -1, 16'h0, -1);
    boundary("f5", 1'b1);
    frame(16'h0070, 4'b0011, 4, 16'h0000, -1, 16'h0, -1);
    boundary("f6", 1'b1);
    frame(16'h0000, 4'b0001, 1, 16'h0304, -1, 16'h0, -1);
    boundary("f7", 1'b1);
    frame(16'h0304, 4'b0111, 5, 16'h1234, -1, 16'h0, -1);
    boundary("f8", 1'b1);
    bus.lz_en = 1'b0;

    // en dropped mid-frame: frame completes, then idle
    frame(16'h1234, 4'hF, -1, 16'h0, -1, 16'h0, 5);
    boundary("f9", 1'b0);
    check("idle nibble", bus.nibble, 4'h0);
    check("idle digit_en", bus.digit_en, 4'h0);
    idle_bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.digit_en !== 4'h0 || bus.frame_done !== 1'b0) idle_bad = 1'b1;
    end
    check("idle after drop", idle_bad, 1'b0);

    // Reset mid-SHOW discards pending load and display
    bus.en = 1'b1;
    tick();
    check("restart load_ack", bus.load_ack, 1'b0);
    check("restart nibble", bus.nibble, 4'h4);
    bus.load = 1'b1;
    bus.data_in = 16'h5555;
    tick();
    bus.load = 1'b0;
    check("show digit_en", bus.digit_en, 4'b0001);
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst nibble", bus.nibble, 4'h0);
    check("midrst digit_en", bus.digit_en, 4'h0);
    check("midrst load_ack", bus.load_ack, 1'b0);
    check("midrst frame_done", bus.frame_done, 1'b0);
    rst_n = 1'b1;
    tick();
    check("reen load_ack", bus.load_ack, 1'b0);
    check("reen nibble", bus.nibble, 4'h0);
    frame(16'h0000, 4'hF, -1, 16'h0, -1, 16'h0, 0);
    boundary("f10", 1'b0);
    tick();
    check("final digit_en", bus.digit_en, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
